// File: rtl/fetch_pc.sv
// Program counter and fetch sequencer in front of the instruction ROM.
// Handles run start, jumps, relative branches, stalls, halt and cycle counting.
module fetch_pc #(
  parameter int A   = 10,
  parameter int OFS = 6,
  parameter int CW  = 16
) (
  input  logic           Clk,
  input  logic           Reset,
  input  logic           Start,
  input  logic [A-1:0]   StartAddr,
  input  logic           Stall,
  input  logic           JumpEn,
  input  logic [A-1:0]   Target,
  input  logic           BranchEn,
  input  logic [OFS-1:0] BranchOfs,
  input  logic           Halt,
  output logic [A-1:0]   ProgCounter,
  output logic           Running,
  output logic           Done,
  output logic [CW-1:0]  CycleCount
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [A-1:0]  r_pc;
  logic [A-1:0]  w_pc_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          r_running;
  logic          r_done;
  logic [A-1:0]  w_ofs_ext;
  logic          w_cnt_sat;

  assign w_ofs_ext = {{(A-OFS){BranchOfs[OFS-1]}}, BranchOfs};
  assign w_cnt_sat = &r_cnt;

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      S_IDLE, S_DONE: begin
        if (Start) begin
          w_state_nxt = S_RUN;
          w_pc_nxt    = StartAddr;
          w_cnt_nxt   = '0;
        end
      end
      S_RUN: begin
        // every RUN edge counts, including stalls and the halting edge
        if (!w_cnt_sat)
          w_cnt_nxt = r_cnt + {{(CW-1){1'b0}}, 1'b1};
        if (Stall) begin
          w_pc_nxt = r_pc;
        end else if (Halt) begin
          w_state_nxt = S_DONE;
        end else if (JumpEn) begin
          w_pc_nxt = Target;
        end else if (BranchEn) begin
          w_pc_nxt = r_pc + w_ofs_ext;
        end else begin
          w_pc_nxt = r_pc + {{(A-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state   <= S_IDLE;
      r_pc      <= '0;
      r_cnt     <= '0;
      r_running <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pc      <= w_pc_nxt;
      r_cnt     <= w_cnt_nxt;
      r_running <= (w_state_nxt == S_RUN);
      r_done    <= (w_state_nxt == S_DONE);
    end
  end

  assign ProgCounter = r_pc;
  assign Running     = r_running;
  assign Done        = r_done;
  assign CycleCount  = r_cnt;

endmodule

// File: tb/tb_fetch_pc.sv
// Directed, table-driven bench for fetch_pc.
// A second instance with a 4-bit counter checks saturation.
module tb_fetch_pc;

  logic       Clk;
  logic       Reset;
  logic       Start;
  logic [9:0] StartAddr;
  logic       Stall;
  logic       JumpEn;
  logic [9:0] Target;
  logic       BranchEn;
  logic [5:0] BranchOfs;
  logic       Halt;

  logic [9:0]  pc;
  logic        run;
  logic        dn;
  logic [15:0] cnt;
  logic [9:0]  pc_s;
  logic        run_s;
  logic        dn_s;
  logic [3:0]  cnt_s;

  int checks = 0;
  int errors = 0;

  fetch_pc #(.A(10), .OFS(6), .CW(16)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start),
    .StartAddr(StartAddr), .Stall(Stall),
    .JumpEn(JumpEn), .Target(Target),
    .BranchEn(BranchEn), .BranchOfs(BranchOfs),
    .Halt(Halt), .ProgCounter(pc),
    .Running(run), .Done(dn), .CycleCount(cnt)
  );

  fetch_pc #(.A(10), .OFS(6), .CW(4)) dut_s (
    .Clk(Clk), .Reset(Reset), .Start(Start),
    .StartAddr(StartAddr), .Stall(Stall),
    .JumpEn(JumpEn), .Target(Target),
    .BranchEn(BranchEn), .BranchOfs(BranchOfs),
    .Halt(Halt), .ProgCounter(pc_s),
    .Running(run_s), .Done(dn_s), .CycleCount(cnt_s)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic        st;
    logic [9:0]  sa;
    logic        stl;
    logic        jmp;
    logic [9:0]  tgt;
    logic        br;
    logic [5:0]  ofs;
    logic        hlt;
    logic [9:0]  pc;
    logic        run;
    logic        dn;
    logic [15:0] cnt;
  } vec_t;

  vec_t tv[$];

  task automatic add(
    input logic st, input logic [9:0] sa,
    input logic stl, input logic jmp,
    input logic [9:0] tgt, input logic br,
    input logic [5:0] ofs, input logic hlt,
    input logic [9:0] epc, input logic erun,
    input logic edn, input logic [15:0] ecnt);
    vec_t v;
    v.st = st;   v.sa = sa;   v.stl = stl;
    v.jmp = jmp; v.tgt = tgt; v.br = br;
    v.ofs = ofs; v.hlt = hlt; v.pc = epc;
    v.run = erun; v.dn = edn; v.cnt = ecnt;
    tv.push_back(v);
  endtask

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d",
               nm, act, exp);
    end
  endtask

  task automatic idle_in();
    Start = 0; StartAddr = '0; Stall = 0;
    JumpEn = 0; Target = '0; BranchEn = 0;
    BranchOfs = '0; Halt = 0;
  endtask

  initial begin
    idle_in();
    Reset = 1'b1;
    #12;
    chk("rst_pc", pc, 0);
    chk("rst_run", run, 0);
    chk("rst_done", dn, 0);
    chk("rst_cnt", cnt, 0);
    @(negedge Clk);
    Reset = 1'b0;

    // start at 0, free run
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    for (int k = 1; k <= 5; k++)
      add(0, 0, 0, 0, 0, 0, 0, 0, 10'(k), 1, 0, 16'(k));
    // jump / branch arithmetic
    add(0, 0, 0, 1, 10, 0, 0, 0, 10, 1, 0, 6);
    add(0, 0, 0, 1, 300, 0, 0, 0, 300, 1, 0, 7);
    add(0, 0, 0, 0, 0, 1, 6'b111101, 0, 297, 1, 0, 8);
    add(0, 0, 0, 0, 0, 1, 6'b011111, 0, 328, 1, 0, 9);
    // Start in RUN is ignored
    add(1, 0, 0, 0, 0, 0, 0, 0, 329, 1, 0, 10);
    // stall overrides jump and halt
    add(0, 0, 0, 1, 50, 0, 0, 0, 50, 1, 0, 11);
    add(0, 0, 1, 1, 7, 0, 0, 1, 50, 1, 0, 12);
    add(0, 0, 1, 1, 7, 0, 0, 1, 50, 1, 0, 13);
    // jump beats branch
    add(0, 0, 0, 1, 7, 1, 6'b000100, 0, 7, 1, 0, 14);
    // halt at 20 after 12 run cycles: need restart
    add(0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 1, 15);
    add(1, 9, 0, 0, 0, 0, 0, 0, 9, 1, 0, 0);
    for (int k = 1; k <= 11; k++)
      add(0, 0, 0, 0, 0, 0, 0, 0, 10'(9 + k), 1, 0, 16'(k));
    add(0, 0, 0, 0, 0, 0, 0, 1, 20, 0, 1, 12);
    for (int k = 0; k < 10; k++)
      add(0, 0, k[0], 1, 3, 1, 6'b000001, 1, 20, 0, 1, 12);
    add(1, 5, 0, 0, 0, 0, 0, 0, 5, 1, 0, 0);
    // wrap-around
    add(0, 0, 0, 0, 0, 0, 0, 1, 5, 0, 1, 1);
    add(1, 1022, 0, 0, 0, 0, 0, 0, 1022, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 1023, 1, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2);
    add(0, 0, 0, 0, 0, 1, 6'b111110, 0, 1022, 1, 0, 3);

    foreach (tv[i]) begin
      @(negedge Clk);
      Start = tv[i].st;     StartAddr = tv[i].sa;
      Stall = tv[i].stl;    JumpEn = tv[i].jmp;
      Target = tv[i].tgt;   BranchEn = tv[i].br;
      BranchOfs = tv[i].ofs; Halt = tv[i].hlt;
      @(posedge Clk);
      #1;
      chk($sformatf("v%0d_pc", i), pc, tv[i].pc);
      chk($sformatf("v%0d_run", i), run, tv[i].run);
      chk($sformatf("v%0d_done", i), dn, tv[i].dn);
      chk($sformatf("v%0d_cnt", i), cnt, tv[i].cnt);
      chk($sformatf("v%0d_cnt4", i), cnt_s,
          (tv[i].cnt > 15) ? 15 : tv[i].cnt);
    end

    // async reset mid-run at PC=123
    @(negedge Clk);
    idle_in();
    JumpEn = 1; Target = 123;
    @(posedge Clk);
    #1;
    chk("pre_rst_pc", pc, 123);
    #2;
    Reset = 1'b1;
    #1;
    chk("arst_pc", pc, 0);
    chk("arst_run", run, 0);
    chk("arst_done", dn, 0);
    chk("arst_cnt", cnt, 0);
    chk("arst_cnt4", cnt_s, 0);
    @(negedge Clk);
    idle_in();
    Reset = 1'b0;
    @(posedge Clk);
    #1;
    chk("idle_hold_pc", pc, 0);
    chk("idle_hold_run", run, 0);

    // saturation of the 4-bit counter
    @(negedge Clk);
    Start = 1;
    @(posedge Clk);
    #1;
    Start = 0;
    repeat (20) @(posedge Clk);
    #1;
    chk("sat_cnt4", cnt_s, 15);
    chk("sat_cnt16", cnt, 20);
    chk("sat_pc", pc, 20);
    chk("sat_run", run_s, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
